decompress1_ctrl: RTL and testbench

Sequencer for the 1-bit decompression unit in the Kyber decryption path. Pulls the 32-byte message from an upstream byte stream, loads it into decompress1 with the index/full handshake, then steps decompress1 through its 128 output pairs, delivering 256 upscaled coefficients downstream over valid/ready. One job per `start`; `done` pulses at the end.

---
 rtl/decompress1_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_decompress1_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decompress1_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decompress1_ctrl
// Description : Sequencer for the 1-bit decompression unit. It loads 32 message
//               bytes into decompress1, then drains 128 coefficient pairs to a
//               valid/ready sink. Optional macro: DECOMP1_CTRL_INDEX_CHECK_EN
//               adds a sticky err output for dec_out_index mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module decompress1_ctrl #(
    parameter int NBYTES  = 32,
    parameter int NPAIRS  = 128,
    parameter int CAP_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        set,
    input  logic        start,
    input  logic        src_valid,
    input  logic [7:0]  src_data,
    output logic        src_ready,
    input  logic        dec_readin_ok,
    output logic [7:0]  dec_din,
    output logic [7:0]  dec_in_index,
    output logic        dec_full_in,
    input  logic        dec_readout_ok,
    output logic        dec_readout,
    input  logic [15:0] dec_dout_1,
    input  logic [15:0] dec_dout_2,
    input  logic [7:0]  dec_out_index,
    output logic        snk_valid,
    input  logic        snk_ready,
    output logic [15:0] snk_data_1,
    output logic [15:0] snk_data_2,
    output logic [7:0]  snk_index,
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
    output logic        err,
`endif
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] LAST_BYTE = 6'(NBYTES - 1);
    localparam logic [7:0] LAST_PAIR = 8'(NPAIRS - 1);
    localparam logic [2:0] CAP_LAT_W = 3'(CAP_LAT);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WAIT_IN  = 4'd1,
        LOAD     = 4'd2,
        FULL     = 4'd3,
        WAIT_OUT = 4'd4,
        ISSUE    = 4'd5,
        CAPTURE  = 4'd6,
        PUSH     = 4'd7,
        DONE     = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  pair_cnt_q, pair_cnt_d;
    logic [2:0]  lat_q, lat_d;
    logic        src_ready_q, src_ready_d;
    logic        dec_full_in_q, dec_full_in_d;
    logic        dec_readout_q, dec_readout_d;
    logic        snk_valid_q, snk_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  dec_din_q, dec_din_d;
    logic [7:0]  dec_in_index_q, dec_in_index_d;
    logic [15:0] snk_data_1_q, snk_data_1_d;
    logic [15:0] snk_data_2_q, snk_data_2_d;
    logic [7:0]  snk_index_q, snk_index_d;
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
    logic        err_q, err_d;
`else
    logic        w_unused_index;
    assign w_unused_index = ^dec_out_index;
`endif

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        pair_cnt_d     = pair_cnt_q;
        lat_d          = lat_q;
        dec_din_d      = dec_din_q;
        dec_in_index_d = dec_in_index_q;
        snk_data_1_d   = snk_data_1_q;
        snk_data_2_d   = snk_data_2_q;
        snk_index_d    = snk_index_q;
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
        err_d          = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WAIT_IN;
                    byte_cnt_d = 6'd0;
                    pair_cnt_d = 8'd0;
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
                    err_d      = 1'b0;
`endif
                end
            end
            WAIT_IN: begin
                if (dec_readin_ok) state_d = LOAD;
            end
            LOAD: begin
                // decompress1 latches readin_ok, so loading is not gated by it here
                if (src_valid) begin
                    dec_din_d      = src_data;
                    dec_in_index_d = {2'b00, byte_cnt_q};
                    byte_cnt_d     = byte_cnt_q + 6'd1;
                    if (byte_cnt_q == LAST_BYTE) state_d = FULL;
                end
            end
            FULL:     state_d = WAIT_OUT;
            WAIT_OUT: begin
                if (dec_readout_ok) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = CAPTURE;
                lat_d   = CAP_LAT_W;
            end
            CAPTURE: begin
                lat_d = lat_q - 3'd1;
                if (lat_d == 3'd0) begin
                    snk_data_1_d = dec_dout_1;
                    snk_data_2_d = dec_dout_2;
                    snk_index_d  = pair_cnt_q;
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
                    if (dec_out_index != pair_cnt_q) err_d = 1'b1;
`endif
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (snk_ready) begin
                    pair_cnt_d = pair_cnt_q + 8'd1;
                    state_d    = (pair_cnt_q == LAST_PAIR) ? DONE : ISSUE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Every control output is a registered decode of the state being entered
        src_ready_d   = (state_d == LOAD);
        dec_full_in_d = (state_d == FULL);
        dec_readout_d = (state_d == ISSUE);
        snk_valid_d   = (state_d == PUSH);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            byte_cnt_q     <= 6'd0;
            pair_cnt_q     <= 8'd0;
            lat_q          <= 3'd0;
            src_ready_q    <= 1'b0;
            dec_full_in_q  <= 1'b0;
            dec_readout_q  <= 1'b0;
            snk_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            dec_din_q      <= 8'd0;
            dec_in_index_q <= 8'd0;
            snk_data_1_q   <= 16'd0;
            snk_data_2_q   <= 16'd0;
            snk_index_q    <= 8'd0;
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
            err_q          <= 1'b0;
`endif
        end else if (set) begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            pair_cnt_q     <= pair_cnt_d;
            lat_q          <= lat_d;
            src_ready_q    <= src_ready_d;
            dec_full_in_q  <= dec_full_in_d;
            dec_readout_q  <= dec_readout_d;
            snk_valid_q    <= snk_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            dec_din_q      <= dec_din_d;
            dec_in_index_q <= dec_in_index_d;
            snk_data_1_q   <= snk_data_1_d;
            snk_data_2_q   <= snk_data_2_d;
            snk_index_q    <= snk_index_d;
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
            err_q          <= err_d;
`endif
        end
    end

    assign src_ready    = src_ready_q;
    assign dec_full_in  = dec_full_in_q;
    assign dec_readout  = dec_readout_q;
    assign snk_valid    = snk_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign dec_din      = dec_din_q;
    assign dec_in_index = dec_in_index_q;
    assign snk_data_1   = snk_data_1_q;
    assign snk_data_2   = snk_data_2_q;
    assign snk_index    = snk_index_q;
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
    assign err          = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decompress1_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decompress1_ctrl
// Description : Directed self-checking bench for decompress1_ctrl with a
//               transaction-level model of the byte/pair streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decompress1_ctrl;

    localparam int NBYTES  = 32;
    localparam int NPAIRS  = 128;
    localparam int CAP_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n, set, start, src_valid, src_ready;
    logic [7:0]  src_data;
    logic        dec_readin_ok, dec_full_in, dec_readout_ok, dec_readout;
    logic [7:0]  dec_din, dec_in_index, dec_out_index;
    logic [15:0] dec_dout_1, dec_dout_2;
    logic        snk_valid, snk_ready, busy, done;
    logic [15:0] snk_data_1, snk_data_2;
    logic [7:0]  snk_index;
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decompress1_ctrl #(.NBYTES(NBYTES), .NPAIRS(NPAIRS), .CAP_LAT(CAP_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .set(set), .start(start),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .dec_readin_ok(dec_readin_ok), .dec_din(dec_din), .dec_in_index(dec_in_index),
        .dec_full_in(dec_full_in), .dec_readout_ok(dec_readout_ok), .dec_readout(dec_readout),
        .dec_dout_1(dec_dout_1), .dec_dout_2(dec_dout_2), .dec_out_index(dec_out_index),
        .snk_valid(snk_valid), .snk_ready(snk_ready),
        .snk_data_1(snk_data_1), .snk_data_2(snk_data_2), .snk_index(snk_index),
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
        .err(err),
`endif
        .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] f1(input int p);
        return {p[7:0], ~p[7:0]};
    endfunction

    function automatic logic [15:0] f2(input int p);
        logic [31:0] t;
        t = p * 37 + 291;
        return t[15:0];
    endfunction

    // Stimulus controls and shared model state
    logic [7:0] bytes [NBYTES];
    logic       drive_en = 1'b0;
    logic       toggle_en = 1'b0;
    int         bad_pair = -1;

    int         nb_acc, np_acc, full_cnt, rd_cnt, done_cnt, cyc, srdy_cyc, last_hs;
    int         job_bytes, job_pairs;
    int         hs_cyc [NPAIRS];
    logic [7:0] exp_din, exp_idx;
    logic       din_valid, hold;
    logic [7:0] h_idx;
    logic [15:0] h_d1, h_d2;

    // Upstream byte source: always offers data, extra bytes past the message are 0xEE
    initial begin : src_drv
        int sent;
        logic phase;
        sent = 0; phase = 1'b0; src_valid = 1'b0; src_data = 8'h00;
        forever begin
            @(posedge clk);
            if (!reset_n) sent = 0;
            else begin
                if (set && src_valid && src_ready) sent++;
                if (set && done) sent = 0;
            end
            #1;
            phase     = ~phase;
            src_valid = drive_en && (!toggle_en || phase);
            src_data  = (sent < NBYTES) ? bytes[sent] : 8'hEE;
        end
    end

    // decompress1 output side: data valid only in the window that a correct capture samples
    initial begin : dec_model
        int pcnt;
        logic [7:0] pi;
        pcnt = 0;
        dec_dout_1 = 16'hDEAD; dec_dout_2 = 16'hBEEF; dec_out_index = 8'hEE;
        forever begin
            @(posedge clk);
            if (!reset_n) pcnt = 0;
            else if (set && dec_full_in) pcnt = 0;
            else if (set && dec_readout) begin
                #1;
                dec_dout_1 = 16'hDEAD; dec_dout_2 = 16'hBEEF; dec_out_index = 8'hEE;
                for (int k = 1; k < CAP_LAT; k++) begin
                    @(posedge clk);
                    while (!set) @(posedge clk);
                end
                #1;
                pi = pcnt[7:0];
                dec_dout_1    = f1(pcnt);
                dec_dout_2    = f2(pcnt);
                dec_out_index = (pcnt == bad_pair) ? (pi ^ 8'h40) : pi;
                @(posedge clk);
                while (!set) @(posedge clk);
                #1;
                dec_dout_1 = 16'hDEAD; dec_dout_2 = 16'hBEEF; dec_out_index = 8'hEE;
                pcnt++;
            end
        end
    end

    // Compare process: checks registered outputs at negedge, consumes handshakes at posedge
    initial begin : monitor
        nb_acc = 0; np_acc = 0; full_cnt = 0; rd_cnt = 0; done_cnt = 0; cyc = 0;
        srdy_cyc = 0; last_hs = 0; job_bytes = 0; job_pairs = 0;
        exp_din = 8'h00; exp_idx = 8'h00; din_valid = 1'b0; hold = 1'b0;
        h_idx = 8'h00; h_d1 = 16'h0; h_d2 = 16'h0;
        for (int i = 0; i < NPAIRS; i++) hs_cyc[i] = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (din_valid) begin
                    chk("dec_din", dec_din, exp_din);
                    chk("dec_in_index", dec_in_index, exp_idx);
                end
                if (nb_acc == NBYTES) chk("src_ready_after_last", src_ready, 0);
            end
            @(posedge clk);
            if (!reset_n) begin
                nb_acc = 0; np_acc = 0; rd_cnt = 0; din_valid = 1'b0;
                exp_din = 8'h00; exp_idx = 8'h00; hold = 1'b0;
            end else begin
                cyc++;
                if (hold) begin
                    chk("hold_valid", snk_valid, 1);
                    chk("hold_index", snk_index, h_idx);
                    chk("hold_data1", snk_data_1, h_d1);
                    chk("hold_data2", snk_data_2, h_d2);
                    hold = 1'b0;
                end
                if (set) begin
                    if (src_ready) srdy_cyc++;
                    if (src_ready && src_valid) begin
                        if (nb_acc >= NBYTES) chk("byte_overrun", nb_acc, NBYTES - 1);
                        exp_din = src_data;
                        exp_idx = nb_acc[7:0];
                        nb_acc++;
                        din_valid = 1'b1;
                    end
                    if (dec_full_in) begin
                        full_cnt++;
                        chk("full_after_all_bytes", nb_acc, NBYTES);
                    end
                    if (dec_readout) begin
                        rd_cnt++;
                        chk("readout_outstanding", rd_cnt, np_acc + 1);
                    end
                    if (snk_valid && snk_ready) begin
                        chk("snk_index", snk_index, np_acc);
                        chk("snk_data_1", snk_data_1, f1(np_acc));
                        chk("snk_data_2", snk_data_2, f2(np_acc));
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
                        chk("err_flag", err, (bad_pair >= 0 && np_acc >= bad_pair));
`endif
                        if (np_acc < NPAIRS) hs_cyc[np_acc] = cyc;
                        np_acc++;
                        last_hs = cyc;
                    end
                    if (done) begin
                        chk("done_pairs", np_acc, NPAIRS);
                        chk("done_after_last", cyc - last_hs, 1);
                        done_cnt++;
                        job_bytes = nb_acc; job_pairs = np_acc;
                        nb_acc = 0; np_acc = 0; rd_cnt = 0;
                    end
                end
                if (snk_valid && !(set && snk_ready)) begin
                    hold = 1'b1; h_idx = snk_index; h_d1 = snk_data_1; h_d2 = snk_data_2;
                end
            end
        end
    end

    task automatic start_job();
        dec_readin_ok = 1'b0; dec_readout_ok = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        repeat (2) @(negedge clk);
        dec_readin_ok = 1'b1;
    endtask

    task automatic wait_full(input int f0);
        for (int k = 0; k < 400 && full_cnt == f0; k++) @(negedge clk);
        if (full_cnt == f0) chk("full_timeout", 0, 1);
        repeat (2) @(negedge clk);
        chk("no_readout_before_ok", rd_cnt, 0);
        dec_readout_ok = 1'b1;
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < 4000 && done_cnt == d0; k++) @(negedge clk);
        if (done_cnt == d0) chk("done_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : flow
        int f0, d0, s0;
        reset_n = 1'b0; set = 1'b1; start = 1'b0; snk_ready = 1'b1;
        dec_readin_ok = 1'b0; dec_readout_ok = 1'b0;
        for (int i = 0; i < NBYTES; i++) bytes[i] = 8'h80 + 8'(i);
        repeat (3) @(negedge clk);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_full_in", dec_full_in, 0);
        chk("rst_readout", dec_readout, 0);
        chk("rst_snk_valid", snk_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dec_din", dec_din, 0);
        chk("rst_dec_in_index", dec_in_index, 0);
        chk("rst_snk_data_1", snk_data_1, 0);
        chk("rst_snk_data_2", snk_data_2, 0);
        chk("rst_snk_index", snk_index, 0);
        reset_n = 1'b1;

        // Abort during load after 10 bytes
        drive_en = 1'b1;
        d0 = done_cnt;
        start_job();
        for (int k = 0; k < 200 && nb_acc < 10; k++) @(negedge clk);
        if (nb_acc < 10) chk("wait_bytes_timeout", nb_acc, 10);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_src_ready", src_ready, 0);
        chk("abort_dec_din", dec_din, 0);
        chk("abort_dec_in_index", dec_in_index, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("abort_no_done", done_cnt, d0);

        // Job 1: continuous streams, bytes 0x00..0x1F
        for (int i = 0; i < NBYTES; i++) bytes[i] = 8'(i);
        f0 = full_cnt; d0 = done_cnt; s0 = srdy_cyc;
        start_job();
        wait_full(f0);
        wait_done(d0);
        chk("job1_bytes", job_bytes, 32);
        chk("job1_pairs", job_pairs, 128);
        chk("job1_full_pulses", full_cnt - f0, 1);
        chk("job1_load_cycles", srdy_cyc - s0, 32);
        chk("job1_pair_period", hs_cyc[11] - hs_cyc[10], 4);
        chk("job1_span", hs_cyc[127] - hs_cyc[0], 508);
        chk("job1_done_pulse", done, 0);
        chk("job1_idle_busy", busy, 0);

        // Job 2: toggling src_valid, readin_ok drop, sink stall, set freeze, stray start
        for (int i = 0; i < NBYTES; i++) bytes[i] = 8'h3C ^ 8'(i * 7);
        toggle_en = 1'b1;
        f0 = full_cnt; d0 = done_cnt;
        start_job();
        for (int k = 0; k < 200 && nb_acc < 5; k++) @(negedge clk);
        dec_readin_ok = 1'b0;
        wait_full(f0);
        for (int k = 0; k < 400 && !(snk_valid && snk_index == 8'd7); k++) @(negedge clk);
        snk_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", snk_valid, 1);
            chk("stall_data1", snk_data_1, 16'h07F8);
            chk("stall_readouts", rd_cnt, 8);
        end
        snk_ready = 1'b1;
        for (int k = 0; k < 400 && !(dec_readout && np_acc == 20); k++) @(negedge clk);
        @(negedge clk);
        set = 1'b0;
        repeat (4) @(negedge clk);
        set = 1'b1;
        for (int k = 0; k < 400 && !(snk_valid && snk_index == 8'd30); k++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0);
        chk("job2_bytes", job_bytes, 32);
        chk("job2_pairs", job_pairs, 128);
        chk("job2_full_pulses", full_cnt - f0, 1);
        chk("job2_freeze_period", hs_cyc[20] - hs_cyc[19], 8);
        repeat (5) @(negedge clk);
        chk("job2_start_ignored", busy, 0);

        // Job 3: wrong index on pair 3; Job 4 clears err with its start
        toggle_en = 1'b0;
        bad_pair = 3;
        d0 = done_cnt; f0 = full_cnt;
        start_job();
        wait_full(f0);
        wait_done(d0);
        chk("job3_pairs", job_pairs, 128);
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
        chk("job3_err_sticky", err, 1);
`endif
        bad_pair = -1;
        d0 = done_cnt; f0 = full_cnt;
        start_job();
`ifdef DECOMP1_CTRL_INDEX_CHECK_EN
        chk("job4_err_cleared", err, 0);
`endif
        wait_full(f0);
        wait_done(d0);
        chk("job4_pairs", job_pairs, 128);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
